// File: rtl/spi_pixel_receiver.sv
// SPI mode-0 slave front end for the 28x28 image buffer: command decode and pixel byte forwarding.
// Latency: write/clear pulses one clk after the synchronised 8th sclk rise; buffer_full drops bytes (sticky overrun).
// Backpressure: none toward the SPI master; dropped pixels are only flagged via overrun_error.
module spi_pixel_receiver #(
  parameter int          NUM_PIXELS  = 784,
  parameter logic [7:0]  CMD_LOAD    = 8'h01,
  parameter logic [7:0]  CMD_CLEAR   = 8'h02,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       buffer_full,
  output logic [7:0] data_out,
  output logic       write_enable,
  output logic       clear_buffer,
  output logic       frame_done,
  output logic       overrun_error,
  output logic [9:0] pixel_count,
  output logic [1:0] debug_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    LOAD   = 2'd2,
    IGNORE = 2'd3
  } state_t;

  localparam logic [9:0] MAX_CNT  = 10'(NUM_PIXELS);
  localparam logic [9:0] LAST_CNT = 10'(NUM_PIXELS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  state_t                 state_q, state_d;

  logic       sclk_s, mosi_s, cs_high, sclk_rise, byte_done;
  logic [7:0] rx_byte;
  logic       we_d, clr_d, fd_d, ovr_set;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_high   = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  // A cs_n rise coinciding with the 8th sclk rise wins: the byte never completes.
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_high;
  assign rx_byte   = {shift_reg[6:0], mosi_s};

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    clr_d   = 1'b0;
    fd_d    = 1'b0;
    ovr_set = 1'b0;
    if (cs_high) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_LOAD) begin
              state_d = LOAD;
            end else begin
              clr_d   = (rx_byte == CMD_CLEAR);
              state_d = IGNORE;
            end
          end
        end
        LOAD: begin
          if (byte_done) begin
            if ((pixel_count < MAX_CNT) && !buffer_full) begin
              we_d = 1'b1;
              fd_d = (pixel_count == LAST_CNT);
            end else begin
              ovr_set = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync     <= '0;
      mosi_sync     <= '0;
      cs_sync       <= '1;
      sclk_prev     <= 1'b0;
      bit_cnt       <= 3'd0;
      shift_reg     <= 8'd0;
      state_q       <= IDLE;
      data_out      <= 8'd0;
      write_enable  <= 1'b0;
      clear_buffer  <= 1'b0;
      frame_done    <= 1'b0;
      overrun_error <= 1'b0;
      pixel_count   <= 10'd0;
    end else begin
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev    <= sclk_s;
      state_q      <= state_d;
      write_enable <= we_d;
      clear_buffer <= clr_d;
      frame_done   <= fd_d;
      if (cs_high) begin
        bit_cnt   <= 3'd0;
        shift_reg <= 8'd0;
      end else if (sclk_rise) begin
        bit_cnt   <= bit_cnt + 3'd1;
        shift_reg <= rx_byte;
      end
      if (we_d) begin
        data_out    <= rx_byte;
        pixel_count <= pixel_count + 10'd1;
      end
      if (clr_d) begin
        pixel_count   <= 10'd0;
        overrun_error <= 1'b0;
      end else if (ovr_set) begin
        overrun_error <= 1'b1;
      end
    end
  end

  assign debug_state = state_q;

endmodule
